// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and encodings for the multi-cycle RV32I control path
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Control word produced by the state decoder; retire marks the instruction's last edge.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/riscv_mc_outdec.sv
// rtl/riscv_mc_outdec.sv - combinational state-to-control-word decoder
import riscv_pkg::*;

module riscv_mc_outdec (
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.adr_src = 1'b1;
        ctrl.retire  = mem_ready;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_BEQ: begin
        // Only beq exists, so the branch is taken purely on the ALU zero flag.
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALU_OP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
        ctrl.retire     = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - main control FSM for the multi-cycle RV32I core
import riscv_pkg::*;

module riscv_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             halt,
  output logic [CNT_W-1:0] instr_retired
);

  state_t           state, state_n;
  ctrl_t            ctrl;
  logic             halt_q;
  logic [CNT_W-1:0] retired_q;

  // ALU decoding of funct fields lives in the ALU decoder, not here.
  logic unused_funct;
  assign unused_funct = ^{funct3, funct7b5};

  riscv_mc_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_R:              state_n = S_EXEC_R;
          OP_I:              state_n = S_EXEC_I;
          OP_BRANCH:         state_n = S_BEQ;
          OP_JAL:            state_n = S_JAL;
          default:           state_n = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_n = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWB:  state_n = S_FETCH;
      S_MEMWR:  if (mem_ready) state_n = S_FETCH;
      S_EXEC_R: state_n = S_ALUWB;
      S_EXEC_I: state_n = S_ALUWB;
      S_ALUWB:  state_n = S_FETCH;
      S_BEQ:    state_n = S_FETCH;
      S_JAL:    state_n = S_ALUWB;
      default:  state_n = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      halt_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_n;
      if (state_n == S_ILLEGAL) halt_q <= 1'b1;
      if (ctrl.retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Reset forces every control output low at once so an in-flight access is abandoned.
  assign mem_req       = ctrl.mem_req   & ~rst;
  assign mem_we        = ctrl.mem_we    & ~rst;
  assign adr_src       = ctrl.adr_src   & ~rst;
  assign ir_write      = ctrl.ir_write  & ~rst;
  assign pc_write      = ctrl.pc_write  & ~rst;
  assign reg_write     = ctrl.reg_write & ~rst;
  assign alu_src_a     = rst ? 2'b00 : ctrl.alu_src_a;
  assign alu_src_b     = rst ? 2'b00 : ctrl.alu_src_b;
  assign alu_op        = rst ? 2'b00 : ctrl.alu_op;
  assign result_src    = rst ? 2'b00 : ctrl.result_src;
  assign halt          = halt_q & ~rst;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb/tb_riscv_mc_ctrl.sv - randomized self-checking bench for riscv_mc_ctrl
module tb_riscv_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic        halt;
  logic [31:0] instr_retired;

  int n_err = 0;
  int n_chk = 0;
  int exp_retired = 0;

  riscv_mc_ctrl #(.CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .result_src    (result_src),
    .halt          (halt),
    .instr_retired (instr_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {18'd0, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, alu_op, result_src, halt};
  endfunction

  // kind: 0 load, 1 store, 2 R-type, 3 I-type, 4 beq, 5 jal
  task automatic run_instr(input int kind, input int fw, input int mw, input logic z);
    logic [6:0] opc_tab [6];
    int base_tab [6];
    int exp_cycles, exp_req, exp_pc, exp_we, exp_rw;
    int cyc, n_ir, ir_cyc, n_rw, rw_cyc, n_we, n_pc, n_req, bad_we, fwr, mwr;
    logic [1:0] rs_at_rw;
    logic fetched, done, is_mem;
    logic [31:0] prev;
    opc_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    base_tab = '{5, 4, 4, 4, 3, 4};
    is_mem = (kind <= 1);
    exp_cycles = base_tab[kind] + fw + (is_mem ? mw : 0);
    exp_req = fw + 1 + (is_mem ? mw + 1 : 0);
    exp_pc = 1 + ((kind == 5) ? 1 : 0) + ((kind == 4 && z) ? 1 : 0);
    exp_we = (kind == 1) ? mw + 1 : 0;
    exp_rw = (kind == 1 || kind == 4) ? 0 : 1;
    opcode = opc_tab[kind];
    zero = z;
    funct3 = 3'($urandom);
    funct7b5 = 1'($urandom);
    cyc = 0; n_ir = 0; ir_cyc = 0; n_rw = 0; rw_cyc = 0; n_we = 0; n_pc = 0;
    n_req = 0; bad_we = 0; fetched = 0; done = 0; rs_at_rw = 2'b11;
    fwr = fw; mwr = mw;
    prev = instr_retired;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (mem_req) begin
        n_req++;
        if (!fetched) begin
          if (fwr > 0) begin mem_ready = 1'b0; fwr--; end
          else mem_ready = 1'b1;
        end else begin
          if (mwr > 0) begin mem_ready = 1'b0; mwr--; end
          else mem_ready = 1'b1;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      cyc++;
      if (ir_write) begin n_ir++; ir_cyc = cyc; fetched = 1'b1; end
      if (reg_write) begin n_rw++; rw_cyc = cyc; rs_at_rw = result_src; end
      if (mem_we) n_we++;
      if (mem_we && !mem_req) bad_we++;
      if (pc_write) n_pc++;
      @(posedge clk); #1;
      if (instr_retired != prev) done = 1'b1;
    end
    exp_retired++;
    check("cycles", cyc, exp_cycles);
    check("ir_write_count", n_ir, 1);
    check("ir_write_cycle", ir_cyc, fw + 1);
    check("reg_write_count", n_rw, exp_rw);
    if (exp_rw == 1) begin
      check("reg_write_cycle", rw_cyc, exp_cycles);
      check("result_src_wb", rs_at_rw, (kind == 0) ? 2'b01 : 2'b00);
    end
    check("mem_we_count", n_we, exp_we);
    check("mem_we_without_req", bad_we, 0);
    check("pc_write_count", n_pc, exp_pc);
    check("mem_req_count", n_req, exp_req);
    check("retired", instr_retired, exp_retired);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    check("reset_outs", outs_vec(), 32'd0);
    check("reset_retired", instr_retired, 32'd0);
    rst = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    run_instr(0, 0, 0, 1'b0);   // lw, zero wait
    run_instr(2, 3, 0, 1'b0);   // add, 3 fetch waits
    run_instr(4, 0, 0, 1'b1);   // beq taken
    run_instr(4, 0, 0, 1'b0);   // beq not taken
    run_instr(1, 0, 2, 1'b0);   // sw, 2 mem waits
    run_instr(5, 1, 0, 1'b0);   // jal
    run_instr(3, 0, 0, 1'b1);   // addi
    run_random(30);

    // reset while a store waits in MEMWR
    @(negedge clk); opcode = 7'b0100011; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0; #1;
    check("memwr_we", mem_we, 1'b1);
    check("memwr_req", mem_req, 1'b1);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("memwr_hold_we", mem_we, 1'b1);
    begin
      logic [31:0] held;
      held = instr_retired;
      check("memwr_held_value", held, exp_retired);
      @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #1;
      check("rst_mid_outs", outs_vec(), 32'd0);
      check("rst_mid_cnt_hold", instr_retired, held);
    end
    @(posedge clk); #1;
    check("rst_mid_cnt_clear", instr_retired, 32'd0);
    @(negedge clk); #1;
    check("rst_mid_outs_next", outs_vec(), 32'd0);
    rst = 1'b0; mem_ready = 1'b0;
    exp_retired = 0;
    @(posedge clk); #1;
    run_random(8);

    // illegal opcode fetch, then recovery by reset
    @(negedge clk); opcode = 7'h7f; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
      check("illegal_halt", halt, 1'b1);
      check("illegal_mem_req", mem_req, 1'b0);
      check("illegal_retired", instr_retired, exp_retired);
    end
    @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #1;
    check("illegal_rst_outs", outs_vec(), 32'd0);
    @(posedge clk); #1;
    check("illegal_rst_cnt", instr_retired, 32'd0);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    check("post_rst_halt", halt, 1'b0);
    check("post_rst_fetch_req", mem_req, 1'b1);
    exp_retired = 0;
    @(posedge clk); #1;
    run_random(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
